// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter sharing one 16:1 single-bit mux among 16 requesters.
// The granted bit goes out over valid/ready, with at most BURST beats per grant.
//
// state | meaning
// IDLE  | no grant held; pick the next requester from ptr onward
// GRANT | requester sel owns the mux; out_valid follows req[sel]
module mux16_rr_arbiter #(
  parameter int N_REQ = 16,
  parameter int BURST = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic [15:0] din,
  input  logic        out_ready,
  output logic [3:0]  sel,
  output logic [15:0] gnt,
  output logic        out_valid,
  output logic        out_data,
  output logic        busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] LAST_BEAT = 4'(BURST - 1);

  generate
    if (N_REQ != 16 || BURST < 1 || BURST > 16) begin : g_bad_param
      $error("mux16_rr_arbiter: N_REQ must be 16 and BURST must be 1..16");
    end
  endgenerate

  state_t     state;
  logic [3:0] ptr;
  logic [3:0] beat_cnt;
  logic [3:0] winner;
  logic       xfer;

  // Rotate so ptr lands at bit 0, then the lowest set bit is the winner's offset.
  function automatic logic [3:0] rr_pick(input logic [15:0] r, input logic [3:0] p);
    logic [31:0] dbl;
    logic [15:0] rot;
    logic [3:0]  off;
    dbl = {r, r} >> p;
    rot = dbl[15:0];
    off = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (rot[i]) off = 4'(i);
    end
    return p + off;
  endfunction

  assign winner    = rr_pick(req, ptr);
  assign busy      = (state == GRANT);
  assign out_valid = busy & req[sel];
  assign out_data  = out_valid & din[sel];
  assign xfer      = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel      <= 4'd0;
      gnt      <= 16'd0;
      ptr      <= 4'd0;
      beat_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            sel      <= winner;
            gnt      <= 16'd1 << winner;
            beat_cnt <= 4'd0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          // Release on the final beat or when the owner drops its request.
          if ((xfer && beat_cnt == LAST_BEAT) || !req[sel]) begin
            ptr      <= sel + 4'd1;
            gnt      <= 16'd0;
            beat_cnt <= 4'd0;
            state    <= IDLE;
          end else if (xfer) begin
            beat_cnt <= beat_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Scoreboard bench for mux16_rr_arbiter: a behavioural model predicts grants and
// transfers (with their cycle numbers); a monitor pops and compares them.
module tb_mux16_rr_arbiter;

  localparam int BURST = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req;
  logic [15:0] din;
  logic        out_ready;
  logic [3:0]  sel;
  logic [15:0] gnt;
  logic        out_valid;
  logic        out_data;
  logic        busy;

  mux16_rr_arbiter #(.N_REQ(16), .BURST(BURST)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din), .out_ready(out_ready),
    .sel(sel), .gnt(gnt), .out_valid(out_valid), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int idx; logic data; } xfer_t;
  typedef struct { int cyc; int idx; } grant_t;

  xfer_t  xq[$];
  grant_t gq[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // model state: whether a grant is held, who holds it, beats taken, next priority
  bit m_busy;
  int m_idx;
  int m_beats;
  int m_ptr;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input bit ok, input longint act, input longint exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  task automatic model_reset();
    m_busy = 0; m_idx = 0; m_beats = 0; m_ptr = 0;
  endtask

  task automatic model_release();
    m_ptr  = (m_idx + 1) % 16;
    m_busy = 0;
  endtask

  // Evaluate the current cycle with the inputs just applied.
  task automatic model_eval();
    if (!m_busy) begin
      if (req != 16'd0) begin
        int  w;
        bit  found;
        found = 0; w = 0;
        for (int i = 0; i < 16; i++) begin
          if (!found && req[(m_ptr + i) % 16]) begin
            w = (m_ptr + i) % 16;
            found = 1;
          end
        end
        gq.push_back('{cyc: cyc + 1, idx: w});
        m_busy = 1; m_idx = w; m_beats = 0;
      end
    end else begin
      if (req[m_idx] && out_ready) begin
        xq.push_back('{cyc: cyc, idx: m_idx, data: din[m_idx]});
        if (m_beats == BURST - 1) model_release();
        else m_beats++;
      end else if (!req[m_idx]) begin
        model_release();
      end
    end
  endtask

  task automatic step(input logic [15:0] r, input logic [15:0] d, input logic rdy);
    @(posedge clk);
    #1;
    req = r; din = d; out_ready = rdy;
    model_eval();
  endtask

  // Monitor
  logic [15:0] prev_gnt = 16'd0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_gnt = 16'd0;
    end else begin
      if (out_valid && out_ready) begin
        if (xq.size() == 0) begin
          check("xfer_unexpected", 0, sel, 16);
        end else begin
          xfer_t e;
          e = xq.pop_front();
          check("xfer_cycle", cyc == e.cyc, cyc, e.cyc);
          check("xfer_sel", sel == 4'(e.idx), sel, e.idx);
          check("xfer_data", out_data == e.data, out_data, e.data);
        end
      end
      if (gnt != 16'd0 && prev_gnt == 16'd0) begin
        if (gq.size() == 0) begin
          check("grant_unexpected", 0, gnt, 0);
        end else begin
          grant_t g;
          g = gq.pop_front();
          check("grant_cycle", cyc == g.cyc, cyc, g.cyc);
          check("grant_sel", sel == 4'(g.idx), sel, g.idx);
          check("grant_onehot", gnt == (16'd1 << g.idx), gnt, 16'd1 << g.idx);
        end
      end
      check("gnt_onehot0", $onehot0(gnt), gnt, 0);
      check("busy_vs_gnt", busy == (gnt != 16'd0), busy, gnt != 16'd0);
      prev_gnt = gnt;
    end
  end

  initial begin
    logic [15:0] r;
    rst_n = 1'b0; req = 16'd0; din = 16'd0; out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_sel", sel == 4'd0, sel, 0);
    check("rst_gnt", gnt == 16'd0, gnt, 0);
    check("rst_busy", busy == 1'b0, busy, 0);
    check("rst_out_valid", out_valid == 1'b0, out_valid, 0);
    check("rst_out_data", out_data == 1'b0, out_data, 0);
    rst_n = 1'b1;

    // single requester 4, regranted after one bubble
    repeat (12) step(16'h0010, 16'h0010, 1'b1);
    repeat (3)  step(16'h0000, 16'h0000, 1'b1);

    // 0 and 15 alternate, wrap from 15 back to 0
    repeat (22) step(16'h8001, 16'hFFFF, 1'b1);
    repeat (3)  step(16'h0000, 16'h0000, 1'b1);

    // everyone requesting: 0..15 then 0
    for (int i = 0; i < 86; i++) step(16'hFFFF, 16'(i * 16'h1357), 1'b1);
    repeat (3) step(16'h0000, 16'h0000, 1'b1);

    // backpressure on requester 3, din toggling while stalled
    for (int i = 0; i < 11; i++) step(16'h0008, (i % 2) ? 16'h0008 : 16'h0000, 1'b0);
    @(negedge clk);
    check("stall_gnt", gnt == 16'h0008, gnt, 16'h0008);
    check("stall_valid", out_valid == 1'b1, out_valid, 1);
    check("stall_busy", busy == 1'b1, busy, 1);
    check("stall_data", out_data == 1'b0, out_data, 0);
    repeat (6) step(16'h0008, 16'h0008, 1'b1);
    repeat (3) step(16'h0000, 16'h0000, 1'b1);

    // early drop by requester 7, then 0 wins from ptr 8
    repeat (3) step(16'h0080, 16'h0080, 1'b1);
    step(16'h0001, 16'h0081, 1'b1);
    repeat (8) step(16'h0081, 16'h0081, 1'b1);
    repeat (3) step(16'h0000, 16'h0000, 1'b1);

    // reset in the middle of a burst to requester 5
    repeat (3) step(16'h0020, 16'hFFFF, 1'b1);
    step(16'h0020, 16'hFFFF, 1'b0);
    #1;
    rst_n = 1'b0;
    req = 16'd0;
    #1;
    check("midrst_gnt", gnt == 16'd0, gnt, 0);
    check("midrst_sel", sel == 4'd0, sel, 0);
    check("midrst_valid", out_valid == 1'b0, out_valid, 0);
    check("midrst_busy", busy == 1'b0, busy, 0);
    model_reset();
    xq.delete();
    gq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) step(16'h0021, 16'h0021, 1'b1);
    repeat (3) step(16'h0000, 16'h0000, 1'b1);

    // random traffic with sticky requests
    r = 16'd0;
    for (int i = 0; i < 500; i++) begin
      r = r ^ 16'($urandom & $urandom & $urandom);
      step(r, 16'($urandom), $urandom_range(0, 3) != 0);
    end
    repeat (6) step(16'h0000, 16'h0000, 1'b1);

    @(negedge clk);
    check("xq_drained", xq.size() == 0, xq.size(), 0);
    check("gq_drained", gq.size() == 0, gq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
